// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - Pong paddle controller: ticked, accelerating, clamped paddle Y position.
// Optional CPU tracking of ballY is compiled in with `define PADDLE_AI_EN.
module paddle_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 56,
    parameter int CENTER_Y    = 232,
    parameter int RIGHT_X     = 614,
    parameter int TICK_W      = 17,
    parameter int MAX_STEP    = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int DEAD_ZONE   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [1:0] keyboard,
    input  logic       ai_mode,
    input  logic       player,
    input  logic [8:0] ballY,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic [2:0] speed
);

    localparam int RUN_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [8:0]       MAX_Y      = 9'(SCREEN_H - PADDLE_H);
    localparam logic [8:0]       CENTER     = 9'(CENTER_Y);
    localparam logic [2:0]       MAX_SPEED  = 3'(MAX_STEP);
    localparam logic [RUN_W-1:0] ACCEL_N    = RUN_W'(ACCEL_TICKS);
    localparam logic [9:0]       HALF_H     = 10'(PADDLE_H / 2);
    localparam logic [9:0]       DZ         = 10'(DEAD_ZONE);

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10
    } dir_t;

    logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
    logic [RUN_W-1:0]  run, run_n;
    logic [8:0]        pos_y_n;
    logic [2:0]        speed_n;
    dir_t              last_dir, last_dir_n;
    dir_t              dir;
    logic              active;
    logic              tick;
    logic [2:0]        step;
    logic [9:0]        down_sum;

    assign posX = player ? 10'(RIGHT_X) : 10'd0;

    assign active = (state == 2'b01) || (state == 2'b10);
    assign tick   = active && (tick_cnt == {TICK_W{1'b1}});

`ifdef PADDLE_AI_EN
    logic [9:0] center_y;
    logic [9:0] ball_ext;

    assign center_y = {1'b0, posY} + HALF_H;
    assign ball_ext = {1'b0, ballY};

    always_comb begin
        dir = DIR_HOLD;
        if (ai_mode) begin
            if (ball_ext > center_y + DZ)
                dir = DIR_DOWN;
            else if (ball_ext + DZ < center_y)
                dir = DIR_UP;
        end else begin
            case (keyboard)
                2'b01:   dir = DIR_DOWN;
                2'b10:   dir = DIR_UP;
                default: dir = DIR_HOLD;
            endcase
        end
    end
`else
    logic unused_ai;
    assign unused_ai = ^{ai_mode, ballY, HALF_H, DZ};

    always_comb begin
        dir = DIR_HOLD;
        case (keyboard)
            2'b01:   dir = DIR_DOWN;
            2'b10:   dir = DIR_UP;
            default: dir = DIR_HOLD;
        endcase
    end
`endif

    // A reversal starts again at one pixel; the old speed is never applied backwards.
    assign step     = (dir == last_dir) ? speed : 3'd1;
    assign down_sum = {1'b0, posY} + {7'd0, step};

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            run      <= '0;
            posY     <= CENTER;
            speed    <= 3'd1;
            last_dir <= DIR_HOLD;
        end else begin
            tick_cnt <= tick_cnt_n;
            run      <= run_n;
            posY     <= pos_y_n;
            speed    <= speed_n;
            last_dir <= last_dir_n;
        end
    end

    always_comb begin
        tick_cnt_n = tick_cnt;
        run_n      = run;
        pos_y_n    = posY;
        speed_n    = speed;
        last_dir_n = last_dir;

        if (!active) begin
            tick_cnt_n = '0;
            run_n      = '0;
            pos_y_n    = CENTER;
            speed_n    = 3'd1;
            last_dir_n = DIR_HOLD;
        end else begin
            tick_cnt_n = tick_cnt + 1'b1;
            if (tick) begin
                last_dir_n = dir;

                case (dir)
                    DIR_DOWN: pos_y_n = (down_sum > {1'b0, MAX_Y}) ? MAX_Y : down_sum[8:0];
                    DIR_UP:   pos_y_n = (posY < {6'd0, step}) ? 9'd0 : posY - {6'd0, step};
                    default:  pos_y_n = posY;
                endcase

                // The tick that starts a direction counts as the first of its run.
                if (dir == DIR_HOLD) begin
                    speed_n = 3'd1;
                    run_n   = '0;
                end else if (dir != last_dir) begin
                    speed_n = 3'd1;
                    run_n   = RUN_W'(1);
                end else if (run + 1'b1 >= ACCEL_N) begin
                    speed_n = (speed < MAX_SPEED) ? speed + 3'd1 : MAX_SPEED;
                    run_n   = '0;
                end else begin
                    run_n   = run + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - directed self-checking bench for paddle_ctrl with TICK_W=4.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [1:0] keyboard;
    logic       ai_mode;
    logic       player;
    logic [8:0] ballY;
    logic [9:0] posX;
    logic [8:0] posY;
    logic [2:0] speed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddle_ctrl #(.TICK_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .keyboard (keyboard),
        .ai_mode  (ai_mode),
        .player   (player),
        .ballY    (ballY),
        .posX     (posX),
        .posY     (posY),
        .speed    (speed)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pos(input string tag, input int y, input int s);
        chk({tag, "_posY"}, {7'd0, posY}, 16'(y));
        chk({tag, "_speed"}, {13'd0, speed}, 16'(s));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        cyc(16 * n);
    endtask

    initial begin
        rst = 1'b1; state = 2'b00; keyboard = 2'b00;
        ai_mode = 1'b0; player = 1'b0; ballY = 9'd0;
        cyc(2);
        pos("reset", 232, 1);

        rst = 1'b0; state = 2'b10;
        cyc(100);
        pos("idle_hold", 232, 1);
        cyc(12);

        keyboard = 2'b01;
        ticks(8);
        pos("accel_8", 240, 2);
        cyc(15);
        chk("between_ticks", {7'd0, posY}, 16'd240);
        cyc(1);
        pos("tick_9", 242, 2);
        ticks(7);
        pos("accel_16", 256, 3);
        ticks(8);
        pos("accel_24", 280, 4);
        ticks(35);
        pos("near_bottom", 420, 4);
        ticks(1);
        pos("clamp_bottom", 424, 4);
        ticks(1);
        pos("stay_bottom", 424, 4);

        keyboard = 2'b10;
        ticks(24);
        pos("up_24", 376, 4);
        ticks(94);
        pos("reach_top", 0, 4);
        ticks(1);
        pos("stay_top", 0, 4);

        keyboard = 2'b01;
        ticks(16);
        pos("down_from_0", 24, 3);
        keyboard = 2'b10;
        ticks(1);
        pos("reverse", 23, 1);
        keyboard = 2'b01;
        ticks(3);
        pos("tap_down", 26, 1);
        keyboard = 2'b10;
        ticks(16);
        pos("up_to_2", 2, 3);
        ticks(1);
        pos("clamp_top", 0, 3);
        ticks(1);
        pos("stay_top2", 0, 3);
        keyboard = 2'b00;
        ticks(1);
        pos("hold_resets", 0, 1);

        keyboard = 2'b01;
        ticks(87);
        pos("mid_300", 300, 4);
        cyc(15);
        state = 2'b11;
        cyc(1);
        pos("done_on_tick", 232, 1);
        cyc(5);
        pos("done_stays", 232, 1);

        player = 1'b1; #1;
        chk("posX_right", {6'd0, posX}, 16'd614);
        player = 1'b0; #1;
        chk("posX_left", {6'd0, posX}, 16'd0);

        state = 2'b01; keyboard = 2'b10;
        ticks(45);
        pos("serve_to_100", 100, 4);

`ifdef PADDLE_AI_EN
        ai_mode = 1'b1; keyboard = 2'b10; ballY = 9'd200;
        ticks(1);
        pos("ai_down", 101, 1);
        ballY = 9'd130;
        ticks(1);
        pos("ai_hold", 101, 1);
        ballY = 9'd50;
        ticks(1);
        pos("ai_up", 100, 1);
`else
        ai_mode = 1'b1; keyboard = 2'b01; ballY = 9'd50;
        ticks(1);
        pos("ai_ignored", 101, 1);
        keyboard = 2'b00;
        ticks(1);
        pos("ai_ignored_hold", 101, 1);
`endif

        state = 2'b00;
        cyc(1);
        pos("start_reload", 232, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
